// File: rtl/vga_timing_core_if.sv
// Renderer-side pixel request/colour interface for vga_timing_core.
// The timing core (master) publishes coordinates and strobes; the renderer (slave) returns colour.
interface vga_timing_core_if #(
  parameter int XW         = 10,
  parameter int YW         = 10,
  parameter int COLOR_BITS = 3
);
  logic [XW-1:0]         pix_x;
  logic [YW-1:0]         pix_y;
  logic                  pix_valid;
  logic                  pix_ce;
  logic                  frame_start;
  logic [COLOR_BITS-1:0] rgb_r;
  logic [COLOR_BITS-1:0] rgb_g;
  logic [COLOR_BITS-1:0] rgb_b;

  modport master (
    output pix_x, pix_y, pix_valid, pix_ce, frame_start,
    input  rgb_r, rgb_g, rgb_b
  );

  modport slave (
    input  pix_x, pix_y, pix_valid, pix_ce, frame_start,
    output rgb_r, rgb_g, rgb_b
  );
endinterface

// File: rtl/vga_timing_core.sv
// Parametrised VGA timing generator and registered pixel output stage.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (adds test_sel input).
module vga_timing_core #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOR_BITS = 3,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_POL   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_sel,
`endif
  vga_timing_core_if.master pix,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk
);

  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   XW       = $clog2(H_TOTAL);
  localparam int   YW       = $clog2(V_TOTAL);
  localparam int   DW       = $clog2(CLK_DIV);
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [DW-1:0] div_cnt;
  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          pix_ce;
  logic          pix_valid;
  logic          hs_act;
  logic          vs_act;
  logic [7:0]    src_r, src_g, src_b;

  // Replicate the narrow colour MSB-first to fill the 8-bit DAC range.
  function automatic logic [7:0] expand(input logic [COLOR_BITS-1:0] c);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) e[7-i] = c[COLOR_BITS-1-(i % COLOR_BITS)];
    return e;
  endfunction

  assign pix_ce    = (div_cnt == DW'(CLK_DIV - 1));
  assign vga_clk   = (div_cnt >= DW'(CLK_DIV / 2));
  assign pix_valid = (h_cnt < XW'(H_ACTIVE)) && (v_cnt < YW'(V_ACTIVE));
  assign hs_act    = (h_cnt >= XW'(H_ACTIVE + H_FP)) && (h_cnt < XW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_act    = (v_cnt >= YW'(V_ACTIVE + V_FP)) && (v_cnt < YW'(V_ACTIVE + V_FP + V_SYNC));
  assign vga_sync_n = 1'b0;

  assign pix.pix_x       = h_cnt;
  assign pix.pix_y       = v_cnt;
  assign pix.pix_valid   = pix_valid;
  assign pix.pix_ce      = pix_ce;
  assign pix.frame_start = pix_ce && (h_cnt == '0) && (v_cnt == '0);

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
      if (pix_ce) begin
        if (h_cnt == XW'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == YW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [XW-1:0] bar_idx;
  assign bar_idx = h_cnt / XW'(H_ACTIVE / 8);
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    src_r = expand(pix.rgb_r);
    src_g = expand(pix.rgb_g);
    src_b = expand(pix.rgb_b);
`ifdef VGA_TEST_PATTERN_EN
    // Bars white, yellow, cyan, green, magenta, red, blue, black fall out of the bar index bits.
    if (test_sel) begin
      src_r = {8{~bar_idx[1]}};
      src_g = {8{~bar_idx[2]}};
      src_b = {8{~bar_idx[0]}};
    end
`endif
  end

  // Colour and sync decoded for (h_cnt, v_cnt) leave together one pixel period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_blank_n <= 1'b0;
      vga_hs      <= ~SYNC_ACT;
      vga_vs      <= ~SYNC_ACT;
    end else if (pix_ce) begin
      vga_r       <= pix_valid ? src_r : 8'h00;
      vga_g       <= pix_valid ? src_g : 8'h00;
      vga_b       <= pix_valid ? src_b : 8'h00;
      vga_blank_n <= pix_valid;
      vga_hs      <= hs_act ? SYNC_ACT : ~SYNC_ACT;
      vga_vs      <= vs_act ? SYNC_ACT : ~SYNC_ACT;
    end
  end

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench: a default-geometry instance for line timing and colour vectors,
// and a small active-high-sync instance for frame timing, vertical blanking and mid-frame reset.
module tb_vga_timing_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  vga_timing_core_if #(.XW(10), .YW(10), .COLOR_BITS(3)) pa ();
  vga_timing_core_if #(.XW(5),  .YW(4),  .COLOR_BITS(3)) pb ();

  logic [7:0] ar, ag, ab, br, bg, bb;
  logic a_hs, a_vs, a_bn, a_sn, a_vc;
  logic b_hs, b_vs, b_bn, b_sn, b_vc;
`ifdef VGA_TEST_PATTERN_EN
  logic sel_a = 1'b0;
  logic sel_b = 1'b0;
`endif

  vga_timing_core dut_a (
    .clk(clk), .rst_n(rst_a),
`ifdef VGA_TEST_PATTERN_EN
    .test_sel(sel_a),
`endif
    .pix(pa),
    .vga_r(ar), .vga_g(ag), .vga_b(ab),
    .vga_hs(a_hs), .vga_vs(a_vs), .vga_blank_n(a_bn), .vga_sync_n(a_sn), .vga_clk(a_vc)
  );

  // H_TOTAL = 24 (sync at 18..20), V_TOTAL = 12 (sync lines 9..10), frame = 576 clk.
  vga_timing_core #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .COLOR_BITS(3), .CLK_DIV(2), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_b),
`ifdef VGA_TEST_PATTERN_EN
    .test_sel(sel_b),
`endif
    .pix(pb),
    .vga_r(br), .vga_g(bg), .vga_b(bb),
    .vga_hs(b_hs), .vga_vs(b_vs), .vga_blank_n(b_bn), .vga_sync_n(b_sn), .vga_clk(b_vc)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_a(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (pa.pix_ce && pa.pix_x == x && pa.pix_y == y) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_b(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pb.pix_ce && pb.pix_x == x && pb.pix_y == y) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int         x;
    int         y;
    logic [2:0] r, g, b;
    logic [7:0] er, eg, eb;
    logic       ebn;
    logic       ehs;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit ok;
    int bad_ce, bad_vc;
    int t656, tf1, tr1, tf2, cyc;
    int f1, f2, vr1, vr2, vf, hr1, hr2, hf;
    logic prev_hs, prev_bvs, prev_bhs;

    // Scan-ordered vectors on dut_a: active, edge of active, porch, sync edges, next line.
    tbl[0] = '{10,  5, 3'b101, 3'b010, 3'b111, 8'hB6, 8'h49, 8'hFF, 1'b1, 1'b1};
    tbl[1] = '{11,  5, 3'b111, 3'b111, 3'b111, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1};
    tbl[2] = '{12,  5, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[3] = '{639, 5, 3'b001, 3'b100, 3'b011, 8'h24, 8'h92, 8'h6D, 1'b1, 1'b1};
    tbl[4] = '{640, 5, 3'b111, 3'b111, 3'b111, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[5] = '{656, 5, 3'b111, 3'b111, 3'b111, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{751, 5, 3'b111, 3'b111, 3'b111, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{752, 5, 3'b111, 3'b111, 3'b111, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[8] = '{799, 5, 3'b111, 3'b111, 3'b111, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[9] = '{0,   6, 3'b110, 3'b011, 3'b100, 8'hDB, 8'h6D, 8'h92, 1'b1, 1'b1};

    rst_a = 1'b0;
    rst_b = 1'b0;
    pa.rgb_r = '0; pa.rgb_g = '0; pa.rgb_b = '0;
    pb.rgb_r = '0; pb.rgb_g = '0; pb.rgb_b = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_pix_ce",   pa.pix_ce, 1'b0);
    check("rst_frame",    pa.frame_start, 1'b0);
    check("rst_xy",       {pa.pix_x, pa.pix_y}, 20'd0);
    check("rst_rgb",      {ar, ag, ab}, 24'd0);
    check("rst_blank_n",  a_bn, 1'b0);
    check("rst_a_syncs",  {a_hs, a_vs}, 2'b11);
    check("rst_b_syncs",  {b_hs, b_vs}, 2'b00);
    check("sync_n_tied",  a_sn, 1'b0);

    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    check("first_pix_ce", pa.pix_ce, 1'b1);
    check("first_frame",  pa.frame_start, 1'b1);
    check("first_xy",     {pa.pix_x, pa.pix_y}, 20'd0);

    // Strobe cadence: pix_ce every second clock, vga_clk high on the second half.
    bad_ce = 0;
    bad_vc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pa.pix_ce !== ((i % 2) == 1)) bad_ce++;
      if (a_vc !== ((i % 2) == 1)) bad_vc++;
    end
    check("pix_ce_cadence",  bad_ce, 0);
    check("vga_clk_cadence", bad_vc, 0);

    // Line timing from hsync edges.
    t656 = -1; tf1 = -1; tr1 = -1; tf2 = -1; cyc = 0;
    prev_hs = a_hs;
    for (int i = 0; i < 5000 && tf2 < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (t656 < 0 && pa.pix_x == 656) t656 = cyc;
      if (prev_hs && !a_hs) begin
        if (tf1 < 0) tf1 = cyc;
        else if (tr1 >= 0) tf2 = cyc;
      end
      if (!prev_hs && a_hs && tf1 >= 0 && tr1 < 0) tr1 = cyc;
      prev_hs = a_hs;
    end
    check("hs_fall_after_656", tf1 - t656, 2);
    check("hs_low_width",      tr1 - tf1, 192);
    check("hs_period",         tf2 - tf1, 1600);

    // Colour / blank / hsync vectors.
    for (int i = 0; i < 10; i++) begin
      pa.rgb_r = tbl[i].r;
      pa.rgb_g = tbl[i].g;
      pa.rgb_b = tbl[i].b;
      wait_a(tbl[i].x, tbl[i].y, ok);
      check($sformatf("v%0d_reach", i), ok, 1'b1);
      check($sformatf("v%0d_valid", i), pa.pix_valid, tbl[i].ebn);
      @(negedge clk);
      check($sformatf("v%0d_r", i),       ar, tbl[i].er);
      check($sformatf("v%0d_g", i),       ag, tbl[i].eg);
      check($sformatf("v%0d_b", i),       ab, tbl[i].eb);
      check($sformatf("v%0d_blank_n", i), a_bn, tbl[i].ebn);
      check($sformatf("v%0d_hs", i),      a_hs, tbl[i].ehs);
    end

`ifdef VGA_TEST_PATTERN_EN
    sel_a = 1'b1;
    pa.rgb_r = 3'b010; pa.rgb_g = 3'b010; pa.rgb_b = 3'b010;
    wait_a(0, 7, ok);
    check("bar_x0_reach", ok, 1'b1);
    @(negedge clk);
    check("bar_x0_white", {ar, ag, ab}, 24'hFFFFFF);
    wait_a(80, 7, ok);
    check("bar_x80_reach", ok, 1'b1);
    @(negedge clk);
    check("bar_x80_yellow", {ar, ag, ab}, 24'hFFFF00);
    wait_a(639, 7, ok);
    check("bar_x639_reach", ok, 1'b1);
    @(negedge clk);
    check("bar_x639_black", {ar, ag, ab, a_bn}, 25'h0000001);
    sel_a = 1'b0;
`endif

    // Frame timing on dut_b (active-high syncs).
    f1 = -1; f2 = -1; vr1 = -1; vr2 = -1; vf = -1; hr1 = -1; hr2 = -1; hf = -1; cyc = 0;
    prev_bvs = b_vs;
    prev_bhs = b_hs;
    for (int i = 0; i < 2000 && (f2 < 0 || vr2 < 0); i++) begin
      @(negedge clk);
      cyc++;
      if (pb.frame_start) begin
        if (f1 < 0) f1 = cyc;
        else if (f2 < 0) f2 = cyc;
      end
      if (!prev_bvs && b_vs) begin
        if (vr1 < 0) vr1 = cyc;
        else if (vr2 < 0) vr2 = cyc;
      end
      if (prev_bvs && !b_vs && vr1 >= 0 && vf < 0) vf = cyc;
      if (!prev_bhs && b_hs) begin
        if (hr1 < 0) hr1 = cyc;
        else if (hr2 < 0) hr2 = cyc;
      end
      if (prev_bhs && !b_hs && hr1 >= 0 && hf < 0) hf = cyc;
      prev_bvs = b_vs;
      prev_bhs = b_hs;
    end
    check("b_frame_period", f2 - f1, 576);
    check("b_vs_period",    vr2 - vr1, 576);
    check("b_vs_high",      vf - vr1, 96);
    check("b_hs_period",    hr2 - hr1, 48);
    check("b_hs_high",      hf - hr1, 6);

    // Vertical blanking: last active line versus first blanked line.
    pb.rgb_r = 3'b111; pb.rgb_g = 3'b111; pb.rgb_b = 3'b111;
    wait_b(5, 7, ok);
    check("b_y7_reach", ok, 1'b1);
    @(negedge clk);
    check("b_y7_active", {br, bg, bb, b_bn}, 25'h1FFFFFF);
    wait_b(5, 8, ok);
    check("b_y8_reach", ok, 1'b1);
    check("b_y8_valid", pb.pix_valid, 1'b0);
    @(negedge clk);
    check("b_y8_blank", {br, bg, bb, b_bn}, 25'h0);

    // Mid-frame asynchronous reset and restart.
    wait_b(10, 6, ok);
    check("b_mid_reach", ok, 1'b1);
    @(negedge clk);
    check("b_mid_before", {br, b_bn}, 9'h1FF);
    #1 rst_b = 1'b0;
    #1;
    check("b_mid_xy",     {pb.pix_x, pb.pix_y}, 9'd0);
    check("b_mid_rgb",    {br, bg, bb}, 24'd0);
    check("b_mid_blank",  b_bn, 1'b0);
    check("b_mid_syncs",  {b_hs, b_vs}, 2'b00);
    check("b_mid_strobe", {pb.pix_ce, pb.frame_start}, 2'b00);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("b_restart_strobe", {pb.pix_ce, pb.frame_start}, 2'b11);
    check("b_restart_xy",     {pb.pix_x, pb.pix_y}, 9'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
